pwm_sample_dac: RTL and testbench
=================================

# pwm_sample_dac

Digital-to-analog playback engine: stores a table of 8-bit sample codes and replays them as a 1-bit PWM stream for an external RC/op-amp reconstruction filter. It is the output-direction counterpart of the op-amp threshold digitizer, which turns an analog level into a digital one. Each sample is held for a fixed number of PWM periods, so a table of repeated codes becomes a stepped waveform.

## Interface
Parameters:
- DATA_W, 8: sample width; also the PWM compare width.
- DEPTH, 128: sample table entries.
- ADDR_W, 7: table address width; `DEPTH` must equal `2**ADDR_W`.
- PWM_PERIOD, 256: clocks per PWM period; must be at least 2.
- SAMPLE_PERIODS, 6: PWM periods per sample; must be at least 1.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  DATA_W  table write data.
- start  in  1  begin playback; sampled only in IDLE.
- stop  in  1  abort playback.
- len  in  8  number of samples to play, starting at index 0.
- busy  out  1  high while in PLAY.
- pwm_out  out  1  PWM bitstream.
- sample_idx  out  ADDR_W  index of the sample being played.
- done  out  1  one-cycle pulse at the end of a pass.

## Operation
- **Sample table:** `DEPTH` x `DATA_W` registers.
  - Written on any cycle with `wr_en`, including during PLAY.
  - Not cleared by reset.
  - Read asynchronously by the fetch logic.
- **Registers:** `state`, `len_q`, `idx`, `rep`, `pwm_cnt`, `duty`, `pwm_out`, `done`.
- **FSM state IDLE:**
  - `busy`, `pwm_out` and `done` are 0 (except the `done` pulse below).
  - On `start && !stop && len != 0`:
    - `len_q` = min(`len`, `DEPTH`).
    - `idx`, `rep` and `pwm_cnt` = 0.
    - `duty` = `mem[0]`.
    - Go to PLAY.
  - `start` with `len == 0` is ignored.
- **FSM state PLAY, every cycle:**
  - `pwm_cnt` increments modulo `PWM_PERIOD`.
  - `pwm_out` = (`pwm_cnt` < `duty`), evaluated on the same-cycle register values and delivered from a flop.
  - `duty == 0` gives a constant low output; `duty >= PWM_PERIOD` gives a constant high output.
- **End of a PWM period** (`pwm_cnt == PWM_PERIOD-1`):
  - If `rep < SAMPLE_PERIODS-1`: `rep++`.
  - Otherwise `rep` = 0 and the sample advances:
    - If `idx < len_q-1`: `idx++` and `duty` = `mem[idx+1]`, so the new sample takes effect with no gap cycle.
    - If `idx == len_q-1`: end of pass (see Configuration).
- **stop in PLAY:** next state is IDLE; `pwm_out` = 0; no `done` pulse.
- **start during PLAY:** ignored.
- **Outputs:** `sample_idx` = `idx`; `busy` = (`state == PLAY`).
- **Table writes during playback:**
  - `duty` is latched at fetch time, so writing the address currently playing changes nothing until that address is fetched again.
  - A write in the same cycle as the fetch of that address: the fetch returns the old value.

## Timing
- **Reset:** `state` = IDLE; `busy`, `pwm_out`, `done` = 0; `sample_idx`, `rep`, `pwm_cnt`, `duty`, `len_q` = 0.
- **Reset mid-PLAY:** the same values apply on the cycle after the `rst` edge; no `done` pulse.
- **Start latency:** `start` sampled at edge T.
  - From T+1: `busy` = 1, `pwm_cnt` = 0.
  - `pwm_out` = 1 iff `mem[0]` > 0.
- **Pass length:** one-shot PLAY lasts exactly `N` = `len_q` x `SAMPLE_PERIODS` x `PWM_PERIOD` cycles, from T+1 to T+N.
  - At T+N+1: `busy` = 0, `done` = 1 for one cycle, `pwm_out` = 0.
- **Simultaneous `start` and `stop` in IDLE:** stop wins; the block stays in IDLE.

## Configuration
Macro `PWM_SAMPLE_DAC_LOOP_EN`:
- **Defined:** at end of pass the block stays in PLAY.
  - `idx` = 0 and `duty` = `mem[0]` in the same cycle.
  - `done` pulses for one cycle aligned with the wrap.
  - `busy` stays 1 until `stop` or `rst`.
- **Undefined (one-shot):** end of pass returns to IDLE with the `done` pulse as described in Timing.
- The port list is identical in both builds.

## Test plan
Bench parameters: `PWM_PERIOD` = 4, `SAMPLE_PERIODS` = 2.
1. **One-shot playback:** write `mem[0..2]` = 0, 2, 4; `start` with `len` = 3.
   - `pwm_out` = 0000_0000, then 1100_1100, then 1111_1111.
   - `sample_idx` steps 0, 1, 2 every 8 cycles.
   - `busy` is high for 24 cycles; `done` pulses at T+25.
2. **Start qualification:**
   - `start` with `len` = 0 → no `busy`, no `done`.
   - `start` with `len` = 200 → plays all 128 entries, total 1024 cycles.
3. **Stop:** `stop` in cycle 5 of PLAY → next cycle `busy` = 0, `pwm_out` = 0, `done` never pulses.
   - `start` and `stop` together in IDLE → remains IDLE.
4. **Reset:** `rst` mid-PLAY → next cycle all outputs are at their reset values.
   - Previously written table contents still play correctly on the next `start`.
5. **Write hazard:** during `sample_idx` = 1, write `mem[1]` = 4.
   - The current sample continues at duty 2.
   - A second pass plays duty 4 for sample 1.
6. **Loop build** (`PWM_SAMPLE_DAC_LOOP_EN` defined), `len` = 2:
   - `idx` sequence is 0, 1, 0, 1, …
   - `done` pulses every 16 cycles with `busy` held at 1.
   - `stop` ends playback with no further `done`.

Source files
------------

// File: rtl/pwm_sample_dac.sv
// Sample-table PWM playback engine: each table entry drives PWM_PERIOD-clock PWM periods, SAMPLE_PERIODS times.
// Optional build macro PWM_SAMPLE_DAC_LOOP_EN replays the table continuously instead of stopping after one pass.
module pwm_sample_dac #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 128,
  parameter int ADDR_W         = 7,
  parameter int PWM_PERIOD     = 256,
  parameter int SAMPLE_PERIODS = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        len,
  output logic              busy,
  output logic              pwm_out,
  output logic [ADDR_W-1:0] sample_idx,
  output logic              done
);

  localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int REP_W = (SAMPLE_PERIODS > 1) ? $clog2(SAMPLE_PERIODS) : 1;
  localparam int LEN_W = ADDR_W + 1;
  localparam int CMP_W = (CNT_W > DATA_W) ? CNT_W : DATA_W;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [REP_W-1:0]  REP_LAST = REP_W'(SAMPLE_PERIODS - 1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] idx;
  logic [REP_W-1:0]  rep;
  logic [CNT_W-1:0]  pwm_cnt;
  logic [DATA_W-1:0] duty;

  logic              period_end, sample_end, pass_end;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [REP_W-1:0]  nxt_rep;
  logic [ADDR_W-1:0] nxt_idx;
  logic [DATA_W-1:0] nxt_duty;

  function automatic logic pwm_level(input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] d);
    return CMP_W'(cnt) < CMP_W'(d);
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Next-cycle playback position; fetches read the table before any same-edge write lands.
  always_comb begin
    period_end = (pwm_cnt == CNT_LAST);
    sample_end = period_end && (rep == REP_LAST);
    pass_end   = sample_end && ({1'b0, idx} == (len_q - LEN_ONE));
    nxt_cnt    = period_end ? '0 : pwm_cnt + CNT_W'(1);
    nxt_rep    = rep;
    nxt_idx    = idx;
    nxt_duty   = duty;
    if (period_end) nxt_rep = sample_end ? '0 : rep + REP_W'(1);
    if (sample_end) begin
      if (pass_end) begin
        nxt_idx  = '0;
        nxt_duty = mem[0];
      end else begin
        nxt_idx  = idx + IDX_ONE;
        nxt_duty = mem[idx + IDX_ONE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      idx     <= '0;
      rep     <= '0;
      pwm_cnt <= '0;
      duty    <= '0;
      pwm_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          pwm_out <= 1'b0;
          if (start && !stop && (len != 8'd0)) begin
            len_q   <= (int'(len) > DEPTH) ? LEN_W'(DEPTH) : LEN_W'(len);
            idx     <= '0;
            rep     <= '0;
            pwm_cnt <= '0;
            duty    <= mem[0];
            pwm_out <= pwm_level('0, mem[0]);
            state   <= PLAY;
          end
        end
        PLAY: begin
          if (stop) begin
            state   <= IDLE;
            pwm_out <= 1'b0;
          end else begin
            pwm_cnt <= nxt_cnt;
            rep     <= nxt_rep;
            idx     <= nxt_idx;
            duty    <= nxt_duty;
            pwm_out <= pwm_level(nxt_cnt, nxt_duty);
            if (pass_end) begin
              done <= 1'b1;
`ifdef PWM_SAMPLE_DAC_LOOP_EN
              state <= PLAY;
`else
              state   <= IDLE;
              pwm_out <= 1'b0;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == PLAY);
  assign sample_idx = idx;

endmodule

// File: tb/tb_pwm_sample_dac.sv
// Bench for pwm_sample_dac with PWM_PERIOD=4, SAMPLE_PERIODS=2: time-based playback model plus directed literal checks.
module tb_pwm_sample_dac;

  localparam int P      = 4;
  localparam int S      = 2;
  localparam int SP     = P * S;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [7:0]        len = '0;
  logic              busy, pwm_out, done;
  logic [ADDR_W-1:0] sample_idx;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [DEPTH];
  bit m_busy = 0, m_pwm = 0, m_done = 0;
  int m_t = 0, m_len = 0, m_idx = 0, m_duty = 0;

  pwm_sample_dac #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .PWM_PERIOD(P), .SAMPLE_PERIODS(S)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .len(len), .busy(busy), .pwm_out(pwm_out),
    .sample_idx(sample_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: playback time t since start; sample index, PWM phase and done all follow from t.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_pwm = 0; m_done = 0; m_idx = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        m_pwm = 0;
        if (start && !stop && len != 0) begin
          m_busy = 1;
          m_len  = (int'(len) > DEPTH) ? DEPTH : int'(len);
          m_t    = 0;
          m_idx  = 0;
          m_duty = m_mem[0];
          m_pwm  = (0 < m_duty);
        end
      end else if (stop) begin
        m_busy = 0; m_pwm = 0;
      end else begin
        m_t++;
        if (m_t == m_len * SP) begin
          m_done = 1;
          m_t    = 0;
`ifndef PWM_SAMPLE_DAC_LOOP_EN
          m_busy = 0;
          m_pwm  = 0;
`endif
        end
        if (m_busy) begin
          if (m_t % SP == 0) begin
            m_idx  = m_t / SP;
            m_duty = m_mem[m_idx];
          end
          m_pwm = (m_t % P) < m_duty;
        end
      end
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  end

  task automatic checkOutput();
    cmp("busy", busy, m_busy);
    cmp("pwm_out", pwm_out, m_pwm);
    cmp("done", done, m_done);
    if (m_busy) cmp("sample_idx", sample_idx, m_idx);
  endtask

  always @(negedge clk) checkOutput();

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic sp, input logic [7:0] l);
    start = s; stop = sp; len = l;
    tick(1);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic writeMem(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic waitIdle(input int budget, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < budget) begin
      cnt++;
      tick(1);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] pat;
    int cnt, seen, first, second;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    $display("[TB] starting");
    tick(2);
    rst = 1'b0;
    cmp("rst_busy", busy, 0);
    cmp("rst_pwm", pwm_out, 0);
    cmp("rst_done", done, 0);
    cmp("rst_idx", sample_idx, 0);

    for (int i = 0; i < DEPTH; i++) writeMem(i, i % 5);
    writeMem(0, 0);
    writeMem(1, 2);
    writeMem(2, 4);

`ifndef PWM_SAMPLE_DAC_LOOP_EN
    // One-shot pass of three samples.
    applyStimulus(1, 0, 3);
    pat = '0; cnt = 0;
    for (int k = 0; k < 24; k++) begin
      pat = {pat[22:0], pwm_out};
      if (busy === 1'b1) cnt++;
      if (k % 8 == 0) cmp($sformatf("t1_idx_c%0d", k + 1), sample_idx, k / 8);
      tick(1);
    end
    cmp("t1_pwm_pattern", pat, 24'b0000_0000_1100_1100_1111_1111);
    cmp("t1_busy_cycles", cnt, 24);
    cmp("t1_done_c25", done, 1);
    cmp("t1_busy_c25", busy, 0);
    tick(1);
    cmp("t1_done_c26", done, 0);

    // Start qualification.
    applyStimulus(1, 0, 0);
    cmp("t2_len0_busy", busy, 0);
    tick(3);
    cmp("t2_len0_busy_late", busy, 0);
    applyStimulus(1, 0, 200);
    waitIdle(2000, cnt);
    cmp("t2_len200_cycles", cnt, 1024);
    cmp("t2_len200_done", done, 1);
    tick(2);
`endif

    // Stop in cycle 5 of PLAY, then start+stop together in IDLE.
    applyStimulus(1, 0, 3);
    tick(4);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    cmp("t3_busy", busy, 0);
    cmp("t3_pwm", pwm_out, 0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (done !== 1'b0) seen++;
      tick(1);
    end
    cmp("t3_no_done", seen, 0);
    applyStimulus(1, 1, 3);
    cmp("t3_start_stop_busy", busy, 0);
    tick(2);
    cmp("t3_start_stop_busy_late", busy, 0);

    // Reset mid-PLAY, then replay from retained table.
    applyStimulus(1, 0, 3);
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    cmp("t4_busy", busy, 0);
    cmp("t4_pwm", pwm_out, 0);
    cmp("t4_done", done, 0);
    cmp("t4_idx", sample_idx, 0);
    applyStimulus(1, 0, 3);
    tick(9);
    cmp("t4_idx_c10", sample_idx, 1);
    cmp("t4_pwm_c10", pwm_out, 1);
    tick(8);
    cmp("t4_idx_c18", sample_idx, 2);
    cmp("t4_pwm_c18", pwm_out, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);

`ifndef PWM_SAMPLE_DAC_LOOP_EN
    // Write to the sample currently playing.
    applyStimulus(1, 0, 2);
    tick(8);
    writeMem(1, 4);
    tick(1);
    cmp("t5_idx_c11", sample_idx, 1);
    cmp("t5_pwm_c11_old_duty", pwm_out, 0);
    waitIdle(100, cnt);
    cmp("t5_remaining", cnt, 6);
    tick(2);
    applyStimulus(1, 0, 2);
    tick(10);
    cmp("t5_pwm_c11_new_duty", pwm_out, 1);
    waitIdle(100, cnt);
    cmp("t5_done", done, 1);
    tick(2);
`else
    // Continuous playback of two samples.
    applyStimulus(1, 0, 2);
    seen = 0; cnt = 0; first = 0; second = 0;
    for (int k = 1; k <= 48; k++) begin
      if (done === 1'b1) begin
        seen++;
        if (seen == 1) first = k;
        if (seen == 2) second = k;
      end
      if (busy === 1'b1) cnt++;
      if (k == 9 || k == 17 || k == 25) cmp($sformatf("t6_idx_c%0d", k), sample_idx, (k == 17) ? 0 : 1);
      tick(1);
    end
    cmp("t6_first_done", first, 17);
    cmp("t6_second_done", second, 33);
    cmp("t6_done_count", seen, 2);
    cmp("t6_busy_cycles", cnt, 48);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    cmp("t6_stop_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0) seen++;
      tick(1);
    end
    cmp("t6_no_done_after_stop", seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
